// File: rtl/serial_display_driver_if.sv
// Bus bundle for serial_display_driver: parallel frame words, refresh request and
// the registered serial/status outputs.
interface serial_display_driver_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 1
);
  logic [CHANNELS*WIDTH-1:0] pdata;
  logic                      refresh_req;
  logic                      busy;
  logic                      frame_done;
  logic                      sck;
  logic [CHANNELS-1:0]       sdat;
  logic                      oe;

  modport master (
    output pdata, refresh_req,
    input  busy, frame_done, sck, sdat, oe
  );

  modport slave (
    input  pdata, refresh_req,
    output busy, frame_done, sck, sdat, oe
  );
endinterface

// File: rtl/serial_display_driver.sv
// Serial display driver: periodically (or on request) shifts CHANNELS words out on a
// shared sck. Optional macro SERIAL_DISPLAY_PENDING_REQ_EN queues a request seen mid-frame.
module serial_display_driver #(
  parameter int          WIDTH     = 16,
  parameter int          CHANNELS  = 1,
  parameter int          DELAY     = 12,
  parameter int          HALF      = 1,
  parameter int          DIRECTION = 1,
  parameter int unsigned ONTIME    = (2 ** DELAY) - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_display_driver_if.slave bus
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [DELAY-1:0] CNT_MAX  = {DELAY{1'b1}};
  localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
  localparam logic [PW-1:0]    LAST_PH  = PW'(HALF - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [DELAY-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*WIDTH-1:0] data_q, data_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [PW-1:0]             ph_q, ph_d;
  logic                      sck_q, sck_d;
  logic [CHANNELS-1:0]       sdat_q, sdat_d;
  logic                      busy_q, busy_d;
  logic                      fd_q, fd_d;
  logic                      oe_q, oe_d;
  logic                      pend_q, pend_d;

  // Bit k of every channel word, taken in shift order.
  function automatic logic [CHANNELS-1:0] pick_bits(input logic [CHANNELS*WIDTH-1:0] words,
                                                    input logic [BW-1:0] k);
    logic [BW-1:0] pos;
    pos = (DIRECTION != 0) ? (LAST_BIT - k) : k;
    for (int c = 0; c < CHANNELS; c++) begin
      pick_bits[c] = words[c*WIDTH + int'(pos)];
    end
  endfunction

  function automatic logic on_window(input logic [DELAY-1:0] c);
    on_window = (32'(c) < ONTIME);
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    sck_d   = sck_q;
    sdat_d  = sdat_q;
    busy_d  = busy_q;
    fd_d    = 1'b0;
    oe_d    = oe_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        // A pending request restarts straight out of the frame_done cycle.
        if ((cnt_q == CNT_MAX) || bus.refresh_req || pend_q) begin
          state_d = SHIFT;
          data_d  = bus.pdata;
          cnt_d   = {DELAY{1'b0}};
          bit_d   = {BW{1'b0}};
          ph_d    = {PW{1'b0}};
          sck_d   = 1'b0;
          sdat_d  = pick_bits(bus.pdata, {BW{1'b0}});
          busy_d  = 1'b1;
          oe_d    = 1'b0;
          pend_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + DELAY'(1'b1);
          oe_d  = on_window(cnt_d);
        end
      end
      SHIFT: begin
`ifdef SERIAL_DISPLAY_PENDING_REQ_EN
        pend_d = pend_q | bus.refresh_req;
`else
        pend_d = 1'b0;
`endif
        if (ph_q != LAST_PH) begin
          ph_d = ph_q + PW'(1'b1);
        end else begin
          ph_d = {PW{1'b0}};
          if (!sck_q) begin
            sck_d = 1'b1;
          end else if (bit_q != LAST_BIT) begin
            bit_d  = bit_q + BW'(1'b1);
            sck_d  = 1'b0;
            sdat_d = pick_bits(data_q, bit_d);
          end else begin
            state_d = IDLE;
            sck_d   = 1'b0;
            busy_d  = 1'b0;
            fd_d    = 1'b1;
            oe_d    = on_window(cnt_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_MAX;
      data_q  <= {(CHANNELS*WIDTH){1'b0}};
      bit_q   <= {BW{1'b0}};
      ph_q    <= {PW{1'b0}};
      sck_q   <= 1'b0;
      sdat_q  <= {CHANNELS{1'b0}};
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      oe_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      sck_q   <= sck_d;
      sdat_q  <= sdat_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
      oe_q    <= oe_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;
  assign bus.sck        = sck_q;
  assign bus.sdat       = sdat_q;
  assign bus.oe         = oe_q;

endmodule
